tdm_demux8: RTL and testbench

- Time-division 1-to-8 demultiplexer. It is the receive-side counterpart of the 8-to-1 word mux: the mux serialises eight channels onto one word stream, and this block redistributes them.
- Accepts one W-bit word per valid cycle, aligned by a frame-sync marker, and collects slots 0..7 into a working bank.
- Presents all eight channels together on registered outputs when a frame completes.
- Tracks lock and counts sync errors.

---
 rtl/tdm_demux8.sv | 145 ++++++++++++++
 tb/tb_tdm_demux8.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux8.sv
// tdm_demux8: receive-side 1-to-8 time-division demultiplexer.
// Valid words are collected into an eight-slot working bank, aligned by frame_sync.
// When the slot-7 word arrives, all eight channels are published together.
// A HUNT/LOCKED tracker flags framing violations and keeps a saturating error count.

// One channel lane: a bank register plus a frame-coherent output register.
module tdm_demux8_lane #(
  parameter int W   = 4,
  parameter int IDX = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  input  logic         wr_en,
  input  logic         load_y,
  output logic [W-1:0] y
);
  // The last lane bypasses its bank, so the slot-7 word lands in Y on its own capture edge.
  localparam bit IS_LAST = (IDX == 7);

  logic [W-1:0] bank_q;

  // Collect this lane's slot word, then publish it on frame completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q <= '0;
      y      <= '0;
    end else begin
      if (wr_en)  bank_q <= din;
      if (load_y) y      <= IS_LAST ? din : bank_q;
    end
  end
endmodule

module tdm_demux8 #(
  parameter int W                = 4,
  parameter int SYNC_EVERY_FRAME = 1,
  parameter int ERR_W            = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     din,
  input  logic             din_valid,
  input  logic             frame_sync,
  output logic [W-1:0]     Y0,
  output logic [W-1:0]     Y1,
  output logic [W-1:0]     Y2,
  output logic [W-1:0]     Y3,
  output logic [W-1:0]     Y4,
  output logic [W-1:0]     Y5,
  output logic [W-1:0]     Y6,
  output logic [W-1:0]     Y7,
  output logic             frame_done,
  output logic             locked,
  output logic [2:0]       slot,
  output logic             sync_err,
  output logic [ERR_W-1:0] err_cnt
);
  localparam int NUM_LANES = 8;
  localparam logic [0:0] HUNT   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]                   state_q, state_nxt;
  logic [2:0]                   slot_q, slot_nxt;
  logic [NUM_LANES-1:0]         wr_sel;
  logic                         load_y, err_nxt;
  logic                         frame_done_q, sync_err_q;
  logic [ERR_W-1:0]             err_cnt_q;
  logic [NUM_LANES-1:0][W-1:0]  y_bus;

  // Framing decisions for the current word: which lane to write, next slot/state, fault.
  always_comb begin
    state_nxt = state_q;
    slot_nxt  = slot_q;
    wr_sel    = '0;
    load_y    = 1'b0;
    err_nxt   = 1'b0;
    if (din_valid) begin
      if (state_q == HUNT) begin
        if (frame_sync) begin
          wr_sel    = NUM_LANES'(1);
          slot_nxt  = 3'd1;
          state_nxt = LOCKED;
        end
      end else if (frame_sync && slot_q != 3'd0) begin
        // Early sync: restart the frame on this word and discard the partial one.
        err_nxt  = 1'b1;
        wr_sel   = NUM_LANES'(1);
        slot_nxt = 3'd1;
      end else if (!frame_sync && slot_q == 3'd0 && SYNC_EVERY_FRAME != 0) begin
        // Missing sync on slot 0: drop the word and reacquire.
        err_nxt   = 1'b1;
        state_nxt = HUNT;
        slot_nxt  = 3'd0;
      end else begin
        wr_sel   = NUM_LANES'(1) << slot_q;
        slot_nxt = slot_q + 3'd1;
        load_y   = (slot_q == 3'd7);
      end
    end
  end

  // Tracker state, output pulses and the saturating error counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= HUNT;
      slot_q       <= 3'd0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_nxt;
      slot_q       <= slot_nxt;
      frame_done_q <= load_y;
      sync_err_q   <= err_nxt;
      if (err_nxt && err_cnt_q != {ERR_W{1'b1}})
        err_cnt_q <= err_cnt_q + ERR_W'(1);
    end
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    tdm_demux8_lane #(.W(W), .IDX(k)) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .din    (din),
      .wr_en  (wr_sel[k]),
      .load_y (load_y),
      .y      (y_bus[k])
    );
  end

  assign Y0         = y_bus[0];
  assign Y1         = y_bus[1];
  assign Y2         = y_bus[2];
  assign Y3         = y_bus[3];
  assign Y4         = y_bus[4];
  assign Y5         = y_bus[5];
  assign Y6         = y_bus[6];
  assign Y7         = y_bus[7];
  assign frame_done = frame_done_q;
  assign locked     = (state_q == LOCKED);
  assign slot       = slot_q;
  assign sync_err   = sync_err_q;
  assign err_cnt    = err_cnt_q;
endmodule

// File: tb/tb_tdm_demux8.sv
// tb_tdm_demux8: two instances (sync required every frame / only to lock) driven
// with the same stream and checked against a frame-level reference model.
module tb_tdm_demux8;
  localparam int W     = 4;
  localparam int ERR_W = 8;
  localparam int EMAX  = (1 << ERR_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [W-1:0] din = '0;
  logic din_valid = 1'b0;
  logic frame_sync = 1'b0;

  logic [W-1:0]     y_o   [2][8];
  logic             fd_o  [2];
  logic             lk_o  [2];
  logic [2:0]       sl_o  [2];
  logic             se_o  [2];
  logic [ERR_W-1:0] ec_o  [2];

  always #5 clk = ~clk;

  tdm_demux8 #(.W(W), .SYNC_EVERY_FRAME(1), .ERR_W(ERR_W)) dut_a (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .frame_sync(frame_sync),
    .Y0(y_o[0][0]), .Y1(y_o[0][1]), .Y2(y_o[0][2]), .Y3(y_o[0][3]),
    .Y4(y_o[0][4]), .Y5(y_o[0][5]), .Y6(y_o[0][6]), .Y7(y_o[0][7]),
    .frame_done(fd_o[0]), .locked(lk_o[0]), .slot(sl_o[0]), .sync_err(se_o[0]), .err_cnt(ec_o[0]));

  tdm_demux8 #(.W(W), .SYNC_EVERY_FRAME(0), .ERR_W(ERR_W)) dut_b (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .frame_sync(frame_sync),
    .Y0(y_o[1][0]), .Y1(y_o[1][1]), .Y2(y_o[1][2]), .Y3(y_o[1][3]),
    .Y4(y_o[1][4]), .Y5(y_o[1][5]), .Y6(y_o[1][6]), .Y7(y_o[1][7]),
    .frame_done(fd_o[1]), .locked(lk_o[1]), .slot(sl_o[1]), .sync_err(se_o[1]), .err_cnt(ec_o[1]));

  int nvec = 0;
  int nmis = 0;

  // Reference model: per instance, a lock flag, the words gathered so far, the last published frame.
  bit           m_lk   [2];
  int           m_fill [2];
  logic [W-1:0] m_buf  [2][8];
  logic [W-1:0] m_y    [2][8];
  bit           m_fd   [2];
  bit           m_se   [2];
  int           m_ec   [2];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic mreset();
    for (int m = 0; m < 2; m++) begin
      m_lk[m] = 0; m_fill[m] = 0; m_fd[m] = 0; m_se[m] = 0; m_ec[m] = 0;
      for (int i = 0; i < 8; i++) begin m_buf[m][i] = '0; m_y[m][i] = '0; end
    end
  endtask

  task automatic mstep(int m, bit sef, logic v, logic fs, logic [W-1:0] d);
    m_fd[m] = 0; m_se[m] = 0;
    if (v) begin
      if (!m_lk[m]) begin
        if (fs) begin m_buf[m][0] = d; m_fill[m] = 1; m_lk[m] = 1; end
      end else if (fs && m_fill[m] != 0) begin
        m_se[m] = 1; m_buf[m][0] = d; m_fill[m] = 1;
      end else if (!fs && m_fill[m] == 0 && sef) begin
        m_se[m] = 1; m_lk[m] = 0;
      end else begin
        m_buf[m][m_fill[m]] = d;
        m_fill[m]++;
        if (m_fill[m] == 8) begin
          for (int i = 0; i < 8; i++) m_y[m][i] = m_buf[m][i];
          m_fd[m] = 1; m_fill[m] = 0;
        end
      end
    end
    if (m_se[m] && m_ec[m] < EMAX) m_ec[m]++;
  endtask

  function automatic logic [8*W-1:0] ybus(int m, bit model);
    logic [8*W-1:0] r;
    for (int i = 0; i < 8; i++) r[i*W +: W] = model ? m_y[m][i] : y_o[m][i];
    return r;
  endfunction

  task automatic chk_model();
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("i%0d.Y", m),          ybus(m, 0), ybus(m, 1));
      chk($sformatf("i%0d.frame_done", m), fd_o[m],    m_fd[m]);
      chk($sformatf("i%0d.locked", m),     lk_o[m],    m_lk[m]);
      chk($sformatf("i%0d.slot", m),       sl_o[m],    m_fill[m]);
      chk($sformatf("i%0d.sync_err", m),   se_o[m],    m_se[m]);
      chk($sformatf("i%0d.err_cnt", m),    ec_o[m],    m_ec[m]);
    end
  endtask

  // One clock: present inputs, step the model on the edge, compare just after it.
  task automatic cyc(logic v, logic fs, logic [W-1:0] d);
    din_valid = v; frame_sync = fs; din = d;
    @(posedge clk);
    mstep(0, 1'b1, v, fs, d);
    mstep(1, 1'b0, v, fs, d);
    #1;
    chk_model();
  endtask

  typedef struct {
    logic         v;
    logic         fs;
    logic [W-1:0] d;
    logic         exp_fd;
    logic         exp_lk;
    logic [2:0]   exp_slot;
  } vec_t;

  vec_t tbl [9];

  initial begin
    logic [8*W-1:0] exp_y;

    for (int i = 0; i < 8; i++)
      tbl[i] = '{v: 1'b1, fs: (i == 0), d: W'(i), exp_fd: (i == 7), exp_lk: 1'b1, exp_slot: 3'((i + 1) % 8)};
    tbl[8] = '{v: 1'b0, fs: 1'b0, d: W'(0), exp_fd: 1'b0, exp_lk: 1'b1, exp_slot: 3'd0};

    mreset();
    #13;
    for (int m = 0; m < 2; m++) begin
      chk("reset.Y", ybus(m, 0), '0);
      chk("reset.locked", lk_o[m], 1'b0);
      chk("reset.err_cnt", ec_o[m], '0);
    end
    rst_n = 1'b1;
    #4;

    // Test 1: one back-to-back frame 0..7, table-driven.
    for (int i = 0; i < 9; i++) begin
      cyc(tbl[i].v, tbl[i].fs, tbl[i].d);
      chk($sformatf("t1[%0d].frame_done", i), fd_o[0], tbl[i].exp_fd);
      chk($sformatf("t1[%0d].locked", i),     lk_o[0], tbl[i].exp_lk);
      chk($sformatf("t1[%0d].slot", i),       sl_o[0], tbl[i].exp_slot);
      if (i == 7) begin
        for (int k = 0; k < 8; k++) exp_y[k*W +: W] = W'(k);
        chk("t1.Y", ybus(0, 0), exp_y);
      end
    end

    // Test 2: idle cycle between every word; Y only moves after the 8th.
    begin
      logic [W-1:0] w2 [8];
      w2 = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0, 4'h1};
      for (int i = 0; i < 8; i++) begin
        cyc(1'b1, i == 0, w2[i]);
        if (i < 7) chk("t2.Y_hold", ybus(0, 0), exp_y);
        cyc(1'b0, 1'b0, 4'h5);
      end
      chk("t2.Y0", y_o[0][0], 4'hA);
      chk("t2.Y7", y_o[0][7], 4'h1);
    end

    // Test 3: early sync at slot 3 restarts the frame on the sync word.
    cyc(1'b1, 1'b1, 4'h4); cyc(1'b1, 1'b0, 4'h5); cyc(1'b1, 1'b0, 4'h6);
    cyc(1'b1, 1'b1, 4'h9);
    chk("t3.sync_err", se_o[0], 1'b1);
    chk("t3.err_cnt", ec_o[0], 8'd1);
    chk("t3.Y0_hold", y_o[0][0], 4'hA);
    for (int i = 1; i < 8; i++) cyc(1'b1, 1'b0, W'(i));
    chk("t3.frame_done", fd_o[0], 1'b1);
    chk("t3.Y0", y_o[0][0], 4'h9);
    chk("t3.Y5", y_o[0][5], 4'h5);

    // Test 4: slot-0 word without sync; instance a drops lock, instance b completes the frame.
    cyc(1'b1, 1'b0, 4'h3);
    chk("t4.a_sync_err", se_o[0], 1'b1);
    chk("t4.a_locked", lk_o[0], 1'b0);
    chk("t4.b_sync_err", se_o[1], 1'b0);
    for (int i = 1; i < 8; i++) cyc(1'b1, 1'b0, W'(8 + i));
    chk("t4.a_locked_hunt", lk_o[0], 1'b0);
    chk("t4.b_frame_done", fd_o[1], 1'b1);
    chk("t4.b_Y0", y_o[1][0], 4'h3);

    // Test 5: 300 sync errors saturate the counter.
    cyc(1'b1, 1'b1, 4'h0);
    for (int i = 0; i < 300; i++) cyc(1'b1, 1'b1, W'(i));
    chk("t5.err_cnt_a", ec_o[0], 8'd255);
    chk("t5.err_cnt_b", ec_o[1], 8'd255);

    // Test 6: asynchronous reset between edges at slot 5.
    for (int i = 0; i < 5; i++) cyc(1'b1, i == 0, W'(i + 2));
    chk("t6.slot5", sl_o[0], 3'd5);
    #2 rst_n = 1'b0;
    din_valid = 1'b0; frame_sync = 1'b0;
    #1;
    mreset();
    chk("t6.slot", sl_o[0], 3'd0);
    chk("t6.locked", lk_o[0], 1'b0);
    chk("t6.err_cnt", ec_o[0], '0);
    chk("t6.Y", ybus(0, 0), '0);
    chk_model();
    @(posedge clk); #3 rst_n = 1'b1;
    #3;
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, W'(i));
    chk("t6.still_hunt", lk_o[0] | lk_o[1], 1'b0);

    // Randomised stream, sync mostly placed where a frame should start.
    for (int n = 0; n < 2000; n++) begin
      logic v, fs;
      v  = ($urandom_range(0, 3) != 0);
      fs = (m_fill[0] == 0) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 19) == 0);
      cyc(v, fs, W'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
